// File: rtl/cnn_pkg.sv
// Shared constants for the conv datapath: pixel width, kernel size, window width and the
// byte position of each kernel tap inside a packed window.
package cnn_pkg;

    localparam int BIT_W = 8;
    localparam int KS    = 3;
    localparam int WIN_W = KS * KS * BIT_W;

    typedef enum logic {
        FILL,
        EMIT
    } win_state_e;

    // Tap (ky,kx) sits at this LSB in a window: (0,0) is the top-left byte at the MSB end.
    function automatic int tap_lsb(input int ky, input int kx);
        return (KS * KS - 1 - (KS * ky + kx)) * BIT_W;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: combinational read, clocked write. A read and a write to the
// same address in one cycle return the old contents, which is what the window shift needs.
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is not reset; rows 0/1 of every frame overwrite it before any window is emitted.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/conv_window_gen.sv
// Turns a row-major pixel stream into 3x3 valid-convolution windows, one per accepted pixel
// once two rows and two columns are buffered, behind a single-entry output register.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BIT_W-1:0] i_pixel,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIN_W-1:0] o_window,
    output logic             o_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_EMIT0 = CW'(KS - 1);
    localparam logic [RW-1:0] ROW_EMIT0 = RW'(KS - 1);

    // Ascending packed ranges put tap [0][0] at the MSB, matching the o_window byte order.
    typedef logic [0:KS-1][0:KS-1][BIT_W-1:0] win_t;

    win_state_e       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    win_t             win_q, win_d, win_shift;
    logic             valid_q, valid_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic             last_q, last_d;
    logic [BIT_W-1:0] lb0_rdata, lb1_rdata;
    logic             accept, emit_pos, col_wrap;

    assign o_ready  = ~valid_q | i_ready;
    assign accept   = i_valid & o_ready & ~i_clear;
    assign emit_pos = (row_q >= ROW_EMIT0) && (col_q >= COL_EMIT0);
    assign col_wrap = (col_q == COL_LAST);

    assign o_valid  = valid_q;
    assign o_window = window_q;
    assign o_last   = last_q;

    // lb0 holds row-1, lb1 holds row-2; lb1 is fed with what lb0 held for this column.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(BIT_W)) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_waddr (col_q),
        .i_wdata (i_pixel),
        .i_raddr (col_q),
        .o_rdata (lb0_rdata)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(BIT_W)) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_waddr (col_q),
        .i_wdata (lb0_rdata),
        .i_raddr (col_q),
        .o_rdata (lb1_rdata)
    );

    always_comb begin
        for (int ky = 0; ky < KS; ky++) begin
            for (int kx = 0; kx < KS - 1; kx++) begin
                win_shift[ky][kx] = win_q[ky][kx+1];
            end
        end
        win_shift[0][KS-1] = lb1_rdata;
        win_shift[1][KS-1] = lb0_rdata;
        win_shift[2][KS-1] = i_pixel;
    end

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path infers a latch.
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        valid_d  = valid_q;
        window_d = window_q;
        last_d   = last_q;

        if (i_clear) begin
            state_d  = FILL;
            col_d    = '0;
            row_d    = '0;
            win_d    = '0;
            valid_d  = 1'b0;
            window_d = '0;
            last_d   = 1'b0;
        end else if (accept) begin
            win_d   = win_shift;
            col_d   = col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
            valid_d = emit_pos;
            last_d  = emit_pos && col_wrap && (row_q == ROW_LAST);
            if (emit_pos) begin
                window_d = win_shift;
            end
            case (state_q)
                FILL:    if (emit_pos && !col_wrap) state_d = EMIT;
                EMIT:    if (col_wrap) state_d = FILL;
                default: state_d = FILL;
            endcase
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FILL;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            valid_q  <= 1'b0;
            window_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            valid_q  <= valid_d;
            window_q <= window_d;
            last_q   <= last_d;
        end
    end

endmodule
